// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM port between instruction fetch and the MEM stage.
// MEM has fixed priority; every access ends with a one-cycle ready pulse to its owner.
module sram_port_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int READ_WAIT = 1,
  parameter int WE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              if_stall,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAX_WAIT = (READ_WAIT > WE_CYCLES) ? READ_WAIT : WE_CYCLES;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             owner_mem_r;

  // Stalls follow the live request so the hazard unit reacts in the same cycle.
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = (mem_rd | mem_wr) & ~mem_ready;

  // Access sequencer: arbitration, SRAM strobe timing and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      owner_mem_r <= 1'b0;
      sram_addr   <= '0;
      sram_dout   <= '0;
      sram_doe    <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      if_ready    <= 1'b0;
      mem_ready   <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A simultaneous read+write request from MEM is served as a write.
          if (mem_wr) begin
            state_r     <= ST_WR_SETUP;
            owner_mem_r <= 1'b1;
            sram_addr   <= mem_addr;
            sram_dout   <= mem_wdata;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_doe    <= 1'b1;
          end else if (mem_rd) begin
            state_r     <= ST_RD;
            owner_mem_r <= 1'b1;
            sram_addr   <= mem_addr;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b0;
            sram_doe    <= 1'b0;
            cnt_r       <= RD_LOAD;
          end else if (if_req) begin
            state_r     <= ST_RD;
            owner_mem_r <= 1'b0;
            sram_addr   <= if_addr;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b0;
            sram_doe    <= 1'b0;
            cnt_r       <= RD_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (cnt_r == '0) begin
            state_r   <= ST_DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (owner_mem_r) begin
              mem_rdata <= sram_din;
              mem_ready <= 1'b1;
            end else begin
              if_rdata <= sram_din;
              if_ready <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WR_SETUP: begin
          state_r   <= ST_WR_PULSE;
          sram_we_n <= 1'b0;
          cnt_r     <= WE_LOAD;
        end
        ST_WR_PULSE: begin
          if (cnt_r == '0) begin
            state_r   <= ST_WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WR_HOLD: begin
          state_r   <= ST_DONE;
          sram_ce_n <= 1'b1;
          sram_doe  <= 1'b0;
          mem_ready <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_doe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sequences the single shared SRAM port between instruction fetch (IF) and the data-memory stage (MEM) of the 16-bit pipeline.
- Owns the multi-cycle SRAM read/write timing: chip enable, output enable, write-enable pulse and data-bus direction.
- Returns read data and one-cycle ready pulses to each requester, and drives stall requests to the hazard unit.
- The MEM-stage load data it returns feeds the writeback select path.

Parameters:
- DATA_W, 16, data width (matches the codebase data bus).
- ADDR_W, 16, address width (matches the codebase address bus).
- READ_WAIT, 1, cycles the read address and OE are held before data is sampled; must be ≥1.
- WE_CYCLES, 1, cycles the write-enable is held low; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF read request; held high and stable until if_ready.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  IF read data, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_rd  in  1  MEM read request; held until mem_ready.
- mem_wr  in  1  MEM write request; held until mem_ready.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_rdata  out  DATA_W  MEM read data, valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- if_stall  out  1  if_req & ~if_ready (combinational).
- mem_stall  out  1  (mem_rd|mem_wr) & ~mem_ready (combinational).
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  data driven toward SRAM.
- sram_doe  out  1  1 = drive sram_dout onto the bus (the tri-state is outside this block).
- sram_din  in  DATA_W  data from the SRAM bus.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. All outputs except the stalls are registered.
- Reset (async, any state, mid-access included):
  - state=IDLE.
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_doe=0, sram_addr=0, sram_dout=0.
  - if_ready=mem_ready=0, if_rdata=mem_rdata=0.
  - Any in-flight access is abandoned; requesters re-issue after reset.
- IDLE arbitration (evaluated at the clock edge):
  - MEM has fixed priority over IF.
  - mem_wr -> WR_SETUP. If mem_wr and mem_rd are both high, the write wins.
  - else mem_rd -> RD with owner=MEM.
  - else if_req -> RD with owner=IF.
  - The chosen address (and write data) is latched at the grant edge and held for the whole access.
- RD: ce_n=0, oe_n=0, doe=0 for exactly READ_WAIT cycles. At the final RD edge, sram_din is latched into the owner's rdata, the owner's ready is set, and the FSM goes to DONE.
- Write sequence:
  - WR_SETUP: 1 cycle, ce_n=0, we_n=1, doe=1.
  - WR_PULSE: WE_CYCLES cycles, we_n=0, doe=1.
  - WR_HOLD: 1 cycle, we_n=1, doe=1.
  - Then DONE with mem_ready set. oe_n stays 1 throughout.
- DONE:
  - Exactly 1 cycle; the ready pulse is high here, ce_n=1, doe=0.
  - Requests are ignored, so the requester drops its request at the next edge. Then IDLE.
- Latency from the grant edge to the cycle in which ready is high:
  - read: READ_WAIT+1 cycles.
  - write: WE_CYCLES+3 cycles.
  - Back-to-back accesses are separated by one DONE cycle plus the IDLE grant cycle.
- Read data registers hold their value after the ready pulse until the next completion for that owner.
- A request that drops before its ready pulse does not abort an access in progress; the access completes and the ready pulse is still issued.
- IF may wait indefinitely while MEM keeps requesting. The pipeline guarantees MEM requests are finite.
- Address and data are never changed while sram_we_n=0.

Test Plan:
- Reset mid-write: assert rst during WR_PULSE -> same cycle we_n=1, doe=0, ce_n=1, readies 0; after release the FSM is IDLE and the SRAM word is not guaranteed.
- IF read, READ_WAIT=1: if_addr=0x0040, model returns 0x1234 -> oe_n low for 1 cycle; if_ready pulses 1 cycle, 2 cycles after grant, with if_rdata=0x1234; if_stall high until then.
- MEM write, WE_CYCLES=1: addr 0x8000, wdata 0xBEEF -> sequence setup/we_n low 1 cycle/hold, doe=1 for 3 cycles; mem_ready 4 cycles after grant; a following read of 0x8000 returns 0xBEEF.
- Simultaneous requests: if_req and mem_rd both asserted in IDLE -> MEM served first (mem_rdata valid), DONE, IDLE, then IF served; if_stall high throughout.
- mem_rd=mem_wr=1 -> a write is performed and oe_n is never asserted.
- Parameter sweep with READ_WAIT=3, WE_CYCLES=2: read ready 4 cycles after grant, write ready 5 cycles after grant; we_n is low for exactly 2 cycles.
